wb_regfile: RTL and testbench
=============================

// Module: wb_regfile
// PURPOSE
//   Write-back end of the MEM/WB pipeline register: the architectural register file.
//   - Consumes the MEM/WB outputs, selects the write-back data, and commits it on the clock edge.
//   - Serves two combinational read ports to the ID stage, with same-cycle write-to-read bypass.
//   - Keeps a count of committed write-backs for debug and performance monitoring.
// PARAMETERS
//   DATA_W   32  register and data-path width in bits
//   ADDR_W   5   register address width; register count = 2**ADDR_W
//   CNT_W    32  width of the write-back commit counter
// PORTS
//   clk_i        in   1       clock; all state updates on posedge
//   rst_i        in   1       asynchronous reset, active-low
//   ALU_Res_i    in   DATA_W  ALU result from MEM/WB
//   Read_Data_i  in   DATA_W  memory load data from MEM/WB
//   RdAddr_i     in   ADDR_W  destination register from MEM/WB
//   MemToReg_i   in   1       1: write Read_Data_i; 0: write ALU_Res_i
//   RegWrite_i   in   1       write enable from MEM/WB
//   RS1addr_i    in   ADDR_W  read port 1 address (ID stage)
//   RS2addr_i    in   ADDR_W  read port 2 address (ID stage)
//   RS1data_o    out  DATA_W  read port 1 data, combinational
//   RS2data_o    out  DATA_W  read port 2 data, combinational
//   WB_Data_o    out  DATA_W  selected write-back data, combinational (for forwarding)
//   WB_Cnt_o     out  CNT_W   number of committed writes, registered
// BEHAVIOUR
//   - Write-back data select:
//     - wb_data = MemToReg_i ? Read_Data_i : ALU_Res_i.
//     - WB_Data_o = wb_data at all times, independent of RegWrite_i.
//   - Write commit (wr_ok):
//     - wr_ok = RegWrite_i && (RdAddr_i != 0) && rst_i.
//     - When wr_ok is high at a posedge, regs[RdAddr_i] <= wb_data.
//     - Latency is 1 cycle to storage, 0 cycles to the read ports (bypass).
//   - Register 0:
//     - Always reads 0.
//     - Writes to address 0 are discarded and are not counted.
//   - Read port n (n = 1, 2):
//     - If RSn addr == 0: output 0.
//     - Else if wr_ok && RSn addr == RdAddr_i: output wb_data (write-first bypass).
//     - Else: output regs[RSn addr].
//     - Both ports are independent; both may bypass in the same cycle.
//   - Commit counter:
//     - WB_Cnt_o increments by 1 on each posedge where wr_ok is high.
//     - Wraps modulo 2**CNT_W with no saturation and no flag.
//   - Reset (rst_i low):
//     - Applies asynchronously, including mid-operation.
//     - All regs clear to 0; WB_Cnt_o clears to 0.
//     - While rst_i is low: no writes occur, no bypass occurs, and the read ports return 0.
//     - The first commit can occur on the first posedge after rst_i rises.
//   - Simultaneous events:
//     - Same-address write and read in one cycle: the read returns the new data.
//     - Writing the same register on consecutive cycles: the last write wins.
//   - Unknowns: X on RegWrite_i while rst_i is high is an illegal input and must be flagged by an assertion.
// TESTING
//   1. Reset: assert rst_i low mid-run after writing 0xDEADBEEF to r5
//      -> RS1data_o=0 for RS1addr_i=5 immediately; WB_Cnt_o=0.
//   2. Write/read: RegWrite=1, MemToReg=0, ALU_Res=0x12345678, Rd=7; next cycle RS1addr=7, RegWrite=0
//      -> RS1data_o=0x12345678; WB_Cnt_o=1.
//   3. Bypass: RegWrite=1, MemToReg=1, Read_Data=0xCAFEF00D, Rd=3, RS1addr=RS2addr=3 in the same cycle
//      -> both outputs 0xCAFEF00D before the edge.
//   4. r0: RegWrite=1, Rd=0, ALU_Res=0xFFFFFFFF
//      -> RS1data_o=0 for addr 0, both same cycle and later; WB_Cnt_o unchanged.
//   5. Disabled write: RegWrite=0, Rd=9, ALU_Res=0x55
//      -> r9 keeps its prior value (0 after reset); WB_Cnt_o unchanged; WB_Data_o=0x55.
//   6. Counter wrap: CNT_W=4, 17 valid writes -> WB_Cnt_o=1.
//      Back-to-back writes to r4 of 0x1 then 0x2 -> r4=0x2.

Source files
------------

// File: rtl/wb_regfile.sv
// Write-back stage register file: selects MEM/WB write-back data, commits it to
// the architectural registers, serves two write-first bypassed read ports and
// counts committed writes.
module wb_regfile #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned CNT_W  = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [DATA_W-1:0] ALU_Res_i,
    input  logic [DATA_W-1:0] Read_Data_i,
    input  logic [ADDR_W-1:0] RdAddr_i,
    input  logic              MemToReg_i,
    input  logic              RegWrite_i,
    input  logic [ADDR_W-1:0] RS1addr_i,
    input  logic [ADDR_W-1:0] RS2addr_i,
    output logic [DATA_W-1:0] RS1data_o,
    output logic [DATA_W-1:0] RS2data_o,
    output logic [DATA_W-1:0] WB_Data_o,
    output logic [CNT_W-1:0]  WB_Cnt_o
);

    localparam int unsigned NumRegs = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_q [NumRegs];
    logic [DATA_W-1:0] regs_d [NumRegs];
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] wb_data;
    logic              wr_ok;

    // Write-back data select and commit qualification; r0 writes are dropped.
    always_comb begin
        wb_data = MemToReg_i ? Read_Data_i : ALU_Res_i;
        wr_ok   = RegWrite_i && (RdAddr_i != '0) && rst_i;
    end

    assign WB_Data_o = wb_data;
    assign WB_Cnt_o  = cnt_q;

    // Next-state for register storage and commit counter (counter wraps freely).
    always_comb begin
        regs_d = regs_q;
        cnt_d  = cnt_q;
        if (wr_ok) begin
            regs_d[RdAddr_i] = wb_data;
            cnt_d            = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // State registers with asynchronous active-low clear.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < int'(NumRegs); i++) begin
                regs_q[i] <= '0;
            end
            cnt_q <= '0;
        end else begin
            regs_q <= regs_d;
            cnt_q  <= cnt_d;
        end
    end

    // Read port 1: r0 and reset read as zero, same-cycle commit is forwarded.
    always_comb begin
        RS1data_o = '0;
        if (rst_i && (RS1addr_i != '0)) begin
            if (wr_ok && (RS1addr_i == RdAddr_i)) begin
                RS1data_o = wb_data;
            end else begin
                RS1data_o = regs_q[RS1addr_i];
            end
        end
    end

    // Read port 2: identical behaviour, independent address.
    always_comb begin
        RS2data_o = '0;
        if (rst_i && (RS2addr_i != '0)) begin
            if (wr_ok && (RS2addr_i == RdAddr_i)) begin
                RS2data_o = wb_data;
            end else begin
                RS2data_o = regs_q[RS2addr_i];
            end
        end
    end

    // An unknown write enable out of reset would corrupt state silently.
    regwrite_known_a: assert property (@(posedge clk_i) rst_i |-> !$isunknown(RegWrite_i));

endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile: a 32-bit counter instance and a 4-bit counter
// instance share all inputs; expected outputs are queued when inputs are driven
// and drained at the following negedge.
module tb_wb_regfile;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] alu_res, read_data;
    logic [4:0]  rd_addr, rs1_addr, rs2_addr;
    logic        mem_to_reg, reg_write;
    logic [31:0] rs1_data, rs2_data, wb_data, wb_cnt;
    logic [31:0] rs1_data4, rs2_data4, wb_data4;
    logic [3:0]  wb_cnt4;

    always #5 clk_i = ~clk_i;

    wb_regfile #(.DATA_W(32), .ADDR_W(5), .CNT_W(32)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .ALU_Res_i(alu_res), .Read_Data_i(read_data),
        .RdAddr_i(rd_addr), .MemToReg_i(mem_to_reg), .RegWrite_i(reg_write),
        .RS1addr_i(rs1_addr), .RS2addr_i(rs2_addr), .RS1data_o(rs1_data),
        .RS2data_o(rs2_data), .WB_Data_o(wb_data), .WB_Cnt_o(wb_cnt)
    );

    wb_regfile #(.DATA_W(32), .ADDR_W(5), .CNT_W(4)) dut4 (
        .clk_i(clk_i), .rst_i(rst_i), .ALU_Res_i(alu_res), .Read_Data_i(read_data),
        .RdAddr_i(rd_addr), .MemToReg_i(mem_to_reg), .RegWrite_i(reg_write),
        .RS1addr_i(rs1_addr), .RS2addr_i(rs2_addr), .RS1data_o(rs1_data4),
        .RS2data_o(rs2_data4), .WB_Data_o(wb_data4), .WB_Cnt_o(wb_cnt4)
    );

    typedef struct {
        string       tag;
        int unsigned sel;
        logic [31:0] exp;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] mdl [32];
    int unsigned mdl_cnt;
    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] actual(input int unsigned sel);
        case (sel)
            0:       return rs1_data;
            1:       return rs2_data;
            2:       return wb_data;
            3:       return wb_cnt;
            4:       return rs1_data4;
            5:       return rs2_data4;
            6:       return wb_data4;
            default: return {28'd0, wb_cnt4};
        endcase
    endfunction

    task automatic push_all(input string tag, input logic [31:0] e1, input logic [31:0] e2,
                            input logic [31:0] ewb, input int unsigned ecnt);
        logic [31:0] c32;
        logic [31:0] c4;
        c32 = ecnt;
        c4  = {28'd0, c32[3:0]};
        sb_q.push_back('{tag: {tag, ".rs1"},  sel: 0, exp: e1});
        sb_q.push_back('{tag: {tag, ".rs2"},  sel: 1, exp: e2});
        sb_q.push_back('{tag: {tag, ".wb"},   sel: 2, exp: ewb});
        sb_q.push_back('{tag: {tag, ".cnt"},  sel: 3, exp: c32});
        sb_q.push_back('{tag: {tag, ".rs1w"}, sel: 4, exp: e1});
        sb_q.push_back('{tag: {tag, ".rs2w"}, sel: 5, exp: e2});
        sb_q.push_back('{tag: {tag, ".wbw"},  sel: 6, exp: ewb});
        sb_q.push_back('{tag: {tag, ".cnt4"}, sel: 7, exp: c4});
    endtask

    task automatic drain();
        exp_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_eq(e.tag, actual(e.sel), e.exp);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [4:0] a, input logic ok,
                                               input logic [4:0] rd, input logic [31:0] wb);
        if (!rst_i || a == 5'd0) return 32'd0;
        if (ok && a == rd) return wb;
        return mdl[a];
    endfunction

    // Called just after a posedge: drive, queue expectations, check at negedge, commit.
    task automatic step(input string tag, input logic we, input logic mtr,
                        input logic [31:0] alu, input logic [31:0] rdat,
                        input logic [4:0] rd, input logic [4:0] a1, input logic [4:0] a2);
        logic [31:0] wb;
        logic        ok;
        reg_write  = we;
        mem_to_reg = mtr;
        alu_res    = alu;
        read_data  = rdat;
        rd_addr    = rd;
        rs1_addr   = a1;
        rs2_addr   = a2;
        wb = mtr ? rdat : alu;
        ok = we && (rd != 5'd0) && rst_i;
        push_all(tag, model_read(a1, ok, rd, wb), model_read(a2, ok, rd, wb), wb, mdl_cnt);
        @(negedge clk_i);
        drain();
        @(posedge clk_i);
        if (ok) begin
            mdl[rd] = wb;
            mdl_cnt++;
        end
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) mdl[i] = 32'd0;
        mdl_cnt = 0;
    endtask

    initial begin
        rst_i = 1'b0;
        reg_write = 1'b0; mem_to_reg = 1'b0; alu_res = '0; read_data = '0;
        rd_addr = '0; rs1_addr = 5'd5; rs2_addr = 5'd7;
        model_reset();
        #2;
        push_all("init", 32'd0, 32'd0, 32'd0, 0);
        drain();
        @(posedge clk_i);
        #1;
        rst_i = 1'b1;

        // Write then read back, counter at 1.
        step("wr7",    1'b1, 1'b0, 32'h12345678, 32'h0, 5'd7, 5'd0, 5'd0);
        step("rd7",    1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd7, 5'd0);
        check_eq("cnt_after_wr7", wb_cnt, 32'd1);
        // Same-cycle bypass on both ports from load data.
        step("byp3",   1'b1, 1'b1, 32'h0, 32'hCAFEF00D, 5'd3, 5'd3, 5'd3);
        // r0 write discarded and not counted.
        step("wr0",    1'b1, 1'b0, 32'hFFFFFFFF, 32'h0, 5'd0, 5'd0, 5'd0);
        step("rd0",    1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd3);
        // Disabled write still shows WB data.
        step("dis9",   1'b0, 1'b0, 32'h55, 32'h0, 5'd9, 5'd9, 5'd0);
        step("rd9",    1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd9, 5'd7);
        // Back-to-back writes to r4, last one wins.
        step("r4a",    1'b1, 1'b0, 32'h1, 32'h0, 5'd4, 5'd4, 5'd0);
        step("r4b",    1'b1, 1'b0, 32'h2, 32'h0, 5'd4, 5'd4, 5'd4);
        step("r4rd",   1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd4, 5'd0);
        check_eq("r4_last", rs1_data, 32'h2);

        for (int i = 0; i < 40; i++) begin
            step("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom,
                 $urandom, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                 5'($urandom_range(0, 31)));
        end

        // Asynchronous reset mid-run after r5 holds DEADBEEF.
        step("wr5",    1'b1, 1'b0, 32'hDEADBEEF, 32'h0, 5'd5, 5'd0, 5'd0);
        step("rd5",    1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd5, 5'd0);
        rst_i = 1'b0;
        reg_write = 1'b1; mem_to_reg = 1'b0; alu_res = 32'hAAAA5555;
        rd_addr = 5'd5; rs1_addr = 5'd5; rs2_addr = 5'd7;
        #1;
        model_reset();
        push_all("rstnow", 32'd0, 32'd0, 32'hAAAA5555, 0);
        drain();
        @(posedge clk_i);
        #1;
        push_all("rsthold", 32'd0, 32'd0, 32'hAAAA5555, 0);
        drain();
        rst_i = 1'b1;
        step("post5",  1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd5, 5'd7);

        // 17 valid commits: 4-bit counter wraps to 1.
        for (int i = 1; i <= 17; i++) begin
            step("wrap", 1'b1, 1'($urandom_range(0, 1)), $urandom, $urandom, 5'(i),
                 5'($urandom_range(0, 31)), 5'(i));
        end
        step("wrapchk", 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd17, 5'd1);
        check_eq("cnt4_wrap", {28'd0, wb_cnt4}, 32'd1);
        check_eq("cnt32_17", wb_cnt, 32'd17);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
